// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the memory access sequencer
package cpu_pkg;
  localparam logic [1:0] KIND_FETCH = 2'd0;
  localparam logic [1:0] KIND_LOAD = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  endfunction
endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one fetch/load/store at a time onto the unified memory
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        busy,
  output logic        ready,
  output logic        err,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  logic [1:0] state, kind, req_kind;
  logic [CNT_W-1:0] cnt;
  logic mis_q, accept, last, req_mis;
  logic [31:0] req_addr;
  always_comb begin
    accept = state == ST_IDLE && (data_req || fetch_req);
    req_addr = data_req ? data_addr : fetch_addr;
    req_kind = data_req ? (data_we ? KIND_STORE : KIND_LOAD) : KIND_FETCH;
    req_mis = misaligned(req_addr);
    last = state == ST_ACCESS && cnt == '0;
  end
  assign busy = state != ST_IDLE;
  assign ready = state == ST_DONE;
  assign err = ready && mis_q;
  // Strobes are gated by reset so an access abandoned by reset never writes
  assign mem_read = state == ST_ACCESS && kind != KIND_STORE && !reset;
  assign mem_write = last && kind == KIND_STORE && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      kind <= KIND_FETCH;
      cnt <= '0;
      mis_q <= 1'b0;
      ir <= '0;
      mdr <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      kind <= req_kind;
      mis_q <= req_mis;
      cnt <= CNT_W'(WAIT_CYCLES);
      state <= req_mis ? ST_DONE : ST_ACCESS;
      if (!req_mis) begin
        mem_addr <= req_addr;
        mem_wdata <= req_kind == KIND_STORE ? data_wdata : '0;
      end
    end else if (state == ST_ACCESS) begin
      if (last) begin
        state <= ST_DONE;
        if (kind == KIND_FETCH) ir <= mem_rdata;
        if (kind == KIND_LOAD) mdr <= mem_rdata;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench over three wait-state configurations
module tb_mem_access_unit;
  localparam int WC[3] = '{0, 2, 3};
  typedef struct {
    int lat;
    logic err;
    logic [31:0] ir, mdr, addr;
    int reads, wrs, wrk;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic fetch_req[3], data_req[3], data_we[3];
  logic [31:0] fetch_addr[3], data_addr[3], data_wdata[3];
  logic busy[3], ready[3], err[3], mem_read[3], mem_write[3];
  logic [31:0] ir[3], mdr[3], mem_addr[3], mem_wdata[3], mem_rdata[3];
  logic [31:0] mem[3][64], model[3][64], exp_ir[3], exp_mdr[3];
  logic poke_en = 1'b0;
  int poke_d = 0;
  logic [5:0] poke_a = '0;
  logic [31:0] poke_v = '0;
  exp_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_unit #(.WAIT_CYCLES(WC[g]), .CNT_W(4)) u_dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req[g]), .fetch_addr(fetch_addr[g]),
      .data_req(data_req[g]), .data_we(data_we[g]),
      .data_addr(data_addr[g]), .data_wdata(data_wdata[g]),
      .busy(busy[g]), .ready(ready[g]), .err(err[g]),
      .ir(ir[g]), .mdr(mdr[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .mem_rdata(mem_rdata[g])
    );
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (mem_write[i]) mem[i][mem_addr[i][7:2]] <= mem_wdata[i];
    if (poke_en) mem[poke_d][poke_a] <= poke_v;
  end
  always_comb for (int i = 0; i < 3; i++) mem_rdata[i] = mem[i][mem_addr[i][7:2]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic poke(input int d, input logic [5:0] a, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_d = d; poke_a = a; poke_v = v;
    model[d][a] = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask
  task automatic run(input int d, input logic fr, input logic [31:0] fa, input logic dr,
                     input logic dwe, input logic [31:0] da, input logic [31:0] dwd, input logic swap);
    exp_t e, r;
    logic [1:0] kd;
    int k, reads, wrs, wrk;
    e.addr = dr ? da : fa;
    kd = dr ? (dwe ? 2'd2 : 2'd1) : 2'd0;
    e.err = e.addr[1:0] != 2'b00;
    e.lat = e.err ? 1 : 2 + WC[d];
    e.reads = (e.err || kd == 2'd2) ? 0 : 1 + WC[d];
    e.wrs = (!e.err && kd == 2'd2) ? 1 : 0;
    e.wrk = e.wrs == 1 ? 1 + WC[d] : 0;
    if (!e.err) begin
      if (kd == 2'd0) exp_ir[d] = model[d][e.addr[7:2]];
      if (kd == 2'd1) exp_mdr[d] = model[d][e.addr[7:2]];
      if (kd == 2'd2) model[d][e.addr[7:2]] = dwd;
    end
    e.ir = exp_ir[d];
    e.mdr = exp_mdr[d];
    sb.push_back(e);
    @(negedge clk);
    fetch_req[d] = fr; fetch_addr[d] = fa;
    data_req[d] = dr; data_we[d] = dwe; data_addr[d] = da; data_wdata[d] = dwd;
    k = 0; reads = 0; wrs = 0; wrk = 0;
    do begin
      @(negedge clk);
      k++;
      if (mem_read[d]) reads++;
      if (mem_write[d]) begin
        wrs++;
        wrk = k;
        chk("mem_wdata", mem_wdata[d], dwd);
      end
      if (mem_read[d] || mem_write[d]) chk("mem_addr", mem_addr[d], e.addr);
      chk("busy_active", 32'(busy[d]), 32'd1);
      if (swap && k == 1) fetch_addr[d] = fa + 32'd4;
    end while (!ready[d] && k < 40);
    fetch_req[d] = 1'b0; data_req[d] = 1'b0; data_we[d] = 1'b0;
    r = sb.pop_front();
    chk("ready_seen", 32'(ready[d]), 32'd1);
    chk("latency", 32'(k), 32'(r.lat));
    chk("err", 32'(err[d]), 32'(r.err));
    chk("ir", ir[d], r.ir);
    chk("mdr", mdr[d], r.mdr);
    chk("read_cycles", 32'(reads), 32'(r.reads));
    chk("write_pulses", 32'(wrs), 32'(r.wrs));
    chk("write_cycle", 32'(wrk), 32'(r.wrk));
    @(negedge clk);
    chk("idle_busy", 32'(busy[d]), 32'd0);
    chk("idle_ready", 32'(ready[d]), 32'd0);
    chk("idle_read", 32'(mem_read[d]), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      fetch_req[i] = 1'b0; data_req[i] = 1'b0; data_we[i] = 1'b0;
      fetch_addr[i] = '0; data_addr[i] = '0; data_wdata[i] = '0;
      exp_ir[i] = '0; exp_mdr[i] = '0;
    end
    poke(0, 6'd0, 32'h2004000A);
    poke(1, 6'd0, 32'h11111111);
    poke(1, 6'd1, 32'h22222222);
    poke(2, 6'd16, 32'h0BADF00D);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_ready_err", 32'({ready[i], err[i]}), 32'd0);
      chk("rst_strobes", 32'({mem_read[i], mem_write[i]}), 32'd0);
      chk("rst_ir", ir[i], 32'd0);
      chk("rst_mdr", mdr[i], 32'd0);
      chk("rst_mem_addr", mem_addr[i], 32'd0);
      chk("rst_mem_wdata", mem_wdata[i], 32'd0);
    end
    run(0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    run(1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hDEADBEEF, 1'b0);
    chk("stored_word", mem[1][32], 32'hDEADBEEF);
    run(1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
    run(1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h82, 32'h0, 1'b0);
    poke(1, 6'd32, 32'hCAFEF00D);
    run(1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
    run(1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    run(1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    run(0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h7, 32'h55555555, 1'b0);
    // Abandon a WAIT_CYCLES=3 store in its second access cycle
    @(negedge clk);
    data_req[2] = 1'b1; data_we[2] = 1'b1; data_addr[2] = 32'h40; data_wdata[2] = 32'h12345678;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy[2]), 32'd1);
      chk("pre_rst_write", 32'(mem_write[2]), 32'd0);
    end
    reset = 1'b1;
    data_req[2] = 1'b0; data_we[2] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy[2]), 32'd0);
    chk("mid_rst_flags", 32'({ready[2], err[2], mem_read[2], mem_write[2]}), 32'd0);
    chk("mid_rst_mem_addr", mem_addr[2], 32'd0);
    chk("mid_rst_mem_wdata", mem_wdata[2], 32'd0);
    chk("mid_rst_ir_mdr", ir[2] | mdr[2], 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_write", 32'(mem_write[2]), 32'd0);
    end
    chk("post_rst_word", mem[2][16], 32'h0BADF00D);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sequencer between the multi-cycle CPU control FSM and the unified instruction/data memory. It accepts one fetch or load/store request at a time and drives the memory address, write data and read/write strobes. It holds the strobes for a configurable number of wait states, captures read data into the instruction register (IR) or memory data register (MDR), and pulses a completion strobe. Misaligned word accesses are rejected without touching memory.

Parameters:
WAIT_CYCLES, 0, extra cycles the memory strobes are held beyond the first (0..15)
CNT_W, 4, width of the wait-state counter; must hold WAIT_CYCLES

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
fetch_req  in  1  instruction fetch request
fetch_addr  in  32  byte address of the instruction (PC)
data_req  in  1  data access request
data_we  in  1  1 = store, 0 = load (valid with data_req)
data_addr  in  32  byte address of the data word
data_wdata  in  32  store data
busy  out  1  unit not in IDLE; requests are ignored
ready  out  1  one-cycle completion pulse
err  out  1  one-cycle misaligned-access pulse, coincident with ready
ir  out  32  instruction register
mdr  out  32  memory data register
mem_addr  out  32  memory byte address
mem_wdata  out  32  memory write data
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_rdata  in  32  combinational memory read data

Behaviour:
- Reset (synchronous, has priority over everything, including mid-access):
  - state=IDLE; ir, mdr, mem_addr, mem_wdata = 0.
  - busy, ready, err, mem_read, mem_write = 0.
  - Any in-flight access is abandoned. No write occurs in or after the reset cycle.
- States: IDLE, ACCESS, DONE. busy=1 in ACCESS and DONE.
- IDLE, request sampling:
  - data_req has priority over fetch_req when both are high; the losing request is dropped, not queued.
  - On accept, latch into internal registers: address, kind (FETCH/LOAD/STORE), and wdata (stores only).
  - If the address has addr[1:0] != 0: go to DONE with err flag set. No memory strobe is ever asserted.
  - Otherwise: go to ACCESS and load counter = WAIT_CYCLES.
- ACCESS:
  - mem_addr = latched address; mem_wdata = latched wdata for stores, 0 otherwise.
  - mem_read = 1 for every ACCESS cycle of FETCH/LOAD.
  - mem_write = 1 only on the final ACCESS cycle (counter==0) of STORE, so exactly one write occurs.
  - Counter decrements each cycle. When counter==0, go to DONE.
  - On that final cycle: FETCH captures mem_rdata into ir; LOAD captures it into mdr. STORE changes neither.
- DONE: ready=1 for exactly one cycle; err=1 only if misaligned; then go to IDLE.
- mem_read and mem_write are 0 outside ACCESS. mem_addr and mem_wdata are registered and hold their last value.
- ir and mdr hold their value until the next successful FETCH/LOAD respectively. A misaligned access leaves both unchanged.
- Latency: request accepted in cycle T (state IDLE) -> ACCESS in T+1..T+1+WAIT_CYCLES -> ready in T+2+WAIT_CYCLES.
  - WAIT_CYCLES=0: ready two cycles after acceptance.
  - Misaligned: ready+err at T+1.
- Back-to-back: the earliest next acceptance is the cycle after DONE.
- Requests in ACCESS or DONE are ignored; the requester must hold req until it sees ready.
- Address is not range-checked. Memory truncation of upper bits is the memory's concern.

Decomposition:
- Shared package (cpu_pkg): access kind encoding (KIND_FETCH=2'd0, KIND_LOAD=2'd1, KIND_STORE=2'd2); state encoding (ST_IDLE, ST_ACCESS, ST_DONE); WORD_ALIGN_MASK=2'b11.
- Single module; no sub-module needed. The wait counter stays inline.

Test Plan:
- Fetch, WAIT_CYCLES=0, mem word 0=0x2004000A: fetch_req with fetch_addr=0x0 at T -> mem_read=1 at T+1, ready at T+2, ir=0x2004000A, mdr unchanged, mem_write never 1.
- Store then load, WAIT_CYCLES=2:
  - Store data_addr=0x80, data_wdata=0xDEADBEEF -> mem_write high only at T+3, ready at T+4.
  - Load 0x80 -> mem_read high 3 cycles, mdr=0xDEADBEEF.
- Misaligned: data_req load at data_addr=0x82 -> ready=1, err=1 at T+1; mem_read=mem_write=0 throughout; mdr unchanged.
- Simultaneous: fetch_req (0x4) and data_req load (0x80) in the same IDLE cycle -> load serviced, mdr updated, ir unchanged; fetch not serviced until re-requested after ready.
- Reset mid-store, WAIT_CYCLES=3: assert reset in the second ACCESS cycle -> next cycle state IDLE, all outputs 0, no mem_write pulse, memory word unchanged.
- Ignored request: fetch_req asserted during ACCESS of a prior fetch -> no second access until after ready; busy=1 during ACCESS and DONE.
